// File: rtl/ha_array_reduce_pipe_8x8.sv
// Reduces four weighted ha_array groups to a saturated 16-bit product through a
// 2-stage valid/ready pipeline, with a saturating accumulator and product counter.
module ha_array_reduce_pipe_8x8 #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [6:0]       ha_array_1_b,
  input  logic [8:0]       ha_array_1_t,
  input  logic [6:0]       ha_array_2_b,
  input  logic [8:0]       ha_array_2_t,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_3_t,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      prod,
  output logic             ovf,
  output logic [ACC_W-1:0] acc,
  output logic             acc_ovf,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [9:0] grp(input logic [6:0] b, input logic [8:0] t);
    return {1'b0, t} + {1'b0, b, 2'b0};
  endfunction

  logic        s1_v, s2_v, s1_en, s2_en, hs;
  logic [12:0] s1_lo, lo_next;
  logic [16:0] s1_hi, hi_next, sum;
  logic [9:0]  g0, g1, g2, g3;

  assign g0 = grp(ha_array_0_b, ha_array_0_t);
  assign g1 = grp(ha_array_1_b, ha_array_1_t);
  assign g2 = grp(ha_array_2_b, ha_array_2_t);
  assign g3 = grp(ha_array_3_b, ha_array_3_t);

  assign lo_next = {3'b0, g0} + {1'b0, g1, 2'b0};
  assign hi_next = {3'b0, g2, 4'b0} + {1'b0, g3, 6'b0};
  assign sum     = {4'b0, s1_lo} + s1_hi;

  assign s2_en     = !s2_v || out_ready;
  assign s1_en     = !s1_v || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_v;
  assign hs        = s2_v && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_lo <= '0;
      s1_hi <= '0;
      s2_v  <= 1'b0;
      prod  <= '0;
      ovf   <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_lo <= lo_next;
          s1_hi <= hi_next;
        end
      end
      if (s2_en) begin
        s2_v <= s1_v;
        if (s1_v) begin
          prod <= sum[16] ? 16'hFFFF : sum[15:0];
          ovf  <= sum[16];
        end
      end
    end
  end

  // Clear is applied to the base value first, so clear+handshake yields acc=prod, cnt=1.
  logic [ACC_W-1:0] acc_base, acc_next;
  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] cnt_base, cnt_next;
  logic             acc_ovf_next;

  always_comb begin
    acc_base     = acc_clr ? '0 : acc;
    cnt_base     = acc_clr ? '0 : cnt;
    acc_ovf_next = acc_clr ? 1'b0 : acc_ovf;
    acc_sum      = {1'b0, acc_base} + {{(ACC_W + 1 - 16){1'b0}}, prod};
    acc_next     = acc_base;
    cnt_next     = cnt_base;
    if (hs) begin
      if (acc_sum[ACC_W]) begin
        acc_next     = '1;
        acc_ovf_next = 1'b1;
      end else begin
        acc_next = acc_sum[ACC_W-1:0];
      end
      if (cnt_base != '1) cnt_next = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      cnt     <= '0;
    end else begin
      acc     <= acc_next;
      acc_ovf <= acc_ovf_next;
      cnt     <= cnt_next;
    end
  end

endmodule

// File: tb/tb_ha_array_reduce_pipe_8x8.sv
// Directed self-checking bench for ha_array_reduce_pipe_8x8 (default and ACC_W=16 instances).
module tb_ha_array_reduce_pipe_8x8;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, acc_clr;
  logic [6:0]  b [4];
  logic [8:0]  t [4];

  logic        in_ready, out_valid, ovf, acc_ovf;
  logic [15:0] prod;
  logic [23:0] acc;
  logic [7:0]  cnt;

  logic        in_ready16, out_valid16, ovf16, acc_ovf16;
  logic [15:0] prod16, acc16;
  logic [7:0]  cnt16;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  ha_array_reduce_pipe_8x8 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(b[0]), .ha_array_0_t(t[0]), .ha_array_1_b(b[1]), .ha_array_1_t(t[1]),
    .ha_array_2_b(b[2]), .ha_array_2_t(t[2]), .ha_array_3_b(b[3]), .ha_array_3_t(t[3]),
    .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready), .prod(prod),
    .ovf(ovf), .acc(acc), .acc_ovf(acc_ovf), .cnt(cnt)
  );

  ha_array_reduce_pipe_8x8 #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .ha_array_0_b(b[0]), .ha_array_0_t(t[0]), .ha_array_1_b(b[1]), .ha_array_1_t(t[1]),
    .ha_array_2_b(b[2]), .ha_array_2_t(t[2]), .ha_array_3_b(b[3]), .ha_array_3_t(t[3]),
    .acc_clr(acc_clr), .out_valid(out_valid16), .out_ready(out_ready), .prod(prod16),
    .ovf(ovf16), .acc(acc16), .acc_ovf(acc_ovf16), .cnt(cnt16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_in();
    for (int k = 0; k < 4; k++) begin
      b[k] = '0;
      t[k] = '0;
    end
  endtask

  // Inputs already set; pulse in_valid, check result 2 edges later, then let it drain.
  task automatic run_one(input string tag, input logic [15:0] exp_prod,
                         input logic exp_ovf, input logic clr);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_prod"}, {16'b0, prod}, {16'b0, exp_prod});
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
    acc_clr = clr;
    tick();
    acc_clr = 1'b0;
    zero_in();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
    zero_in();
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_prod", {16'b0, prod}, 32'd0);
    chk("rst_acc", {8'b0, acc}, 32'd0);
    chk("rst_cnt", {24'b0, cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_one("zero", 16'h0000, 1'b0, 1'b0);
    t[0] = 9'h001;
    run_one("w_t0", 16'h0001, 1'b0, 1'b0);
    b[2] = 7'h01;
    run_one("w_b2", 16'h0040, 1'b0, 1'b0);
    b[3] = 7'h7F; t[3] = 9'h1FF;
    run_one("g3max", 16'hFEC0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      b[k] = 7'h7F;
      t[k] = 9'h1FF;
    end
    run_one("allmax", 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: A=1, B=16, C=64
    out_ready = 1'b0;
    in_valid = 1'b1; t[0] = 9'h001;
    #1 chk("bp_ready_a", {31'b0, in_ready}, 32'd1);
    tick();
    zero_in(); b[1] = 7'h01;
    #1 chk("bp_ready_b", {31'b0, in_ready}, 32'd1);
    tick();
    zero_in(); t[3] = 9'h001;
    #1 chk("bp_ready_c", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_hold_a0", {16'b0, prod}, 32'd1);
    repeat (3) tick();
    chk("bp_hold_a3", {16'b0, prod}, 32'd1);
    chk("bp_ready_c3", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1 chk("bp_ready_release", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_b", {16'b0, prod}, 32'd16);
    chk("bp_b_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("bp_c", {16'b0, prod}, 32'd64);
    chk("bp_c_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);
    zero_in();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    t[0] = 9'd100;
    run_one("p100", 16'd100, 1'b0, 1'b0);
    t[0] = 9'd200;
    run_one("p200", 16'd200, 1'b0, 1'b0);
    t[0] = 9'd300;
    run_one("p300", 16'd300, 1'b0, 1'b0);
    chk("acc600", {8'b0, acc}, 32'd600);
    chk("cnt3", {24'b0, cnt}, 32'd3);
    t[0] = 9'd50;
    run_one("p50clr", 16'd50, 1'b0, 1'b1);
    chk("acc_clr_hs", {8'b0, acc}, 32'd50);
    chk("cnt_clr_hs", {24'b0, cnt}, 32'd1);

    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("acc_clr_only", {8'b0, acc}, 32'd0);
    chk("cnt_clr_only", {24'b0, cnt}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      b[k] = 7'h7F;
      t[k] = 9'h1FF;
    end
    run_one("sat_a", 16'hFFFF, 1'b1, 1'b0);
    chk("acc16_ffff", {16'b0, acc16}, 32'hFFFF);
    chk("acc16_ovf0", {31'b0, acc_ovf16}, 32'd0);
    t[0] = 9'h001;
    run_one("sat_b", 16'h0001, 1'b0, 1'b0);
    chk("acc16_sat", {16'b0, acc16}, 32'hFFFF);
    chk("acc16_ovf1", {31'b0, acc_ovf16}, 32'd1);
    chk("cnt16_2", {24'b0, cnt16}, 32'd2);
    chk("acc24_nosat", {8'b0, acc}, 32'h10000);
    chk("acc24_ovf0", {31'b0, acc_ovf}, 32'd0);

    // Fill both stages, then assert reset between clock edges
    out_ready = 1'b0;
    in_valid = 1'b1; t[0] = 9'd7;
    repeat (2) tick();
    in_valid = 1'b0;
    chk("mid_full_valid", {31'b0, out_valid}, 32'd1);
    chk("mid_full_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_acc", {8'b0, acc}, 32'd0);
    chk("mid_rst_cnt", {24'b0, cnt}, 32'd0);
    chk("mid_rst_acc16_ovf", {31'b0, acc_ovf16}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_rst_empty", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
